// File: rtl/ring_window_reader.sv
// Sweeps LEN head-relative ring-buffer offsets from a base through a fixed 2-cycle read port
// and streams the samples out with valid/ready; issue is credit-limited so the skid FIFO never overflows.
module ring_window_reader #(
  parameter int ENTRIES    = 2048,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDRSIZE  = $clog2(ENTRIES),
  localparam int LENSIZE   = ADDRSIZE + 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDRSIZE-1:0]   base_in,
  input  logic [LENSIZE-1:0]    len_in,
  output logic [ADDRSIZE-1:0]   rb_read_addr_out,
  output logic                  rb_read_trigger_out,
  input  logic                  rb_read_ready_in,
  input  logic [DATA_WIDTH-1:0] rb_data_in,
  input  logic                  rb_data_valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDRSIZE-1:0]   index_out,
  output logic                  last_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [LENSIZE:0] ENT_W   = (LENSIZE+1)'(ENTRIES);
  localparam logic [CNTW:0]    DEPTH_W = (CNTW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDRSIZE-1:0]   base_q;
  logic [LENSIZE-1:0]    len_q;
  logic [LENSIZE-1:0]    issued_q;
  logic [LENSIZE-1:0]    xfer_q;
  logic [ADDRSIZE-1:0]   ret_q;
  logic [CNTW-1:0]       outst_q;
  logic [CNTW-1:0]       cnt_q;
  logic [PTRW-1:0]       wr_q, rd_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] fifo_dat  [FIFO_DEPTH];
  logic [ADDRSIZE-1:0]   fifo_idx  [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];

  logic [LENSIZE:0]      addr_sum;
  logic [LENSIZE:0]      addr_wrap;
  logic                  credit_ok;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  start_acc;

  assign addr_sum  = {2'b00, base_q} + {1'b0, issued_q};
  assign addr_wrap = (addr_sum >= ENT_W) ? (addr_sum - ENT_W) : addr_sum;
  assign credit_ok = ({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_W;
  assign issue     = (state_q == S_ISSUE) && rb_read_ready_in && (issued_q < len_q) && credit_ok;
  // Returns with nothing outstanding are leftovers from before a reset.
  assign push      = rb_data_valid_in && (outst_q != '0);
  assign pop       = (cnt_q != '0) && ready_in;
  assign start_acc = (state_q == S_IDLE) && start_in;

  assign rb_read_addr_out    = addr_wrap[ADDRSIZE-1:0];
  assign rb_read_trigger_out = issue;

  assign valid_out = (cnt_q != '0);
  assign data_out  = valid_out ? fifo_dat[rd_q]  : '0;
  assign index_out = valid_out ? fifo_idx[rd_q]  : '0;
  assign last_out  = valid_out ? fifo_last[rd_q] : 1'b0;
  // busy covers DONE so it drops in the same cycle the registered done pulse rises.
  assign busy_out  = (state_q != S_IDLE);
  assign done_out  = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = (len_in == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (issue && (issued_q + LENSIZE'(1) == len_q)) state_d = S_DRAIN;
      S_DRAIN: if ((outst_q == '0) && (cnt_q == '0) && (xfer_q == len_q)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      xfer_q   <= '0;
      ret_q    <= '0;
      outst_q  <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DONE);
      if (start_acc) begin
        base_q   <= base_in;
        len_q    <= len_in;
        issued_q <= '0;
        xfer_q   <= '0;
        ret_q    <= '0;
      end else begin
        if (issue) issued_q <= issued_q + LENSIZE'(1);
        if (push)  ret_q    <= ret_q + ADDRSIZE'(1);
        if (pop)   xfer_q   <= xfer_q + LENSIZE'(1);
      end
      case ({issue, push})
        2'b10:   outst_q <= outst_q + CNTW'(1);
        2'b01:   outst_q <= outst_q - CNTW'(1);
        default: outst_q <= outst_q;
      endcase
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push) wr_q <= wr_q + PTRW'(1);
      if (pop)  rd_q <= rd_q + PTRW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_dat[wr_q]  <= rb_data_in;
      fifo_idx[wr_q]  <= ret_q;
      fifo_last[wr_q] <= ({1'b0, ret_q} + LENSIZE'(1)) == len_q;
    end
  end

endmodule

// File: tb/tb_ring_window_reader.sv
// Directed bench: ring-buffer model with value = 0xA000 + offset, table of sweeps plus a reset-mid-sweep sequence.
module tb_ring_window_reader;

  localparam int E  = 32;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int AW = 5;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic [LW-1:0] len_in = '0;
  logic [AW-1:0] rb_read_addr_out;
  logic          rb_read_trigger_out;
  logic          rb_ready = 1'b1;
  logic [DW-1:0] rb_dat = '0;
  logic          rb_vld = 1'b0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] index_out;
  logic          last_out;
  logic          valid_out;
  logic          ready_in = 1'b1;
  logic          busy_out;
  logic          done_out;

  always #5 clk = ~clk;

  ring_window_reader #(.ENTRIES(E), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .base_in(base_in), .len_in(len_in),
    .rb_read_addr_out(rb_read_addr_out), .rb_read_trigger_out(rb_read_trigger_out),
    .rb_read_ready_in(rb_ready), .rb_data_in(rb_dat), .rb_data_valid_in(rb_vld),
    .data_out(data_out), .index_out(index_out), .last_out(last_out), .valid_out(valid_out),
    .ready_in(ready_in), .busy_out(busy_out), .done_out(done_out)
  );

  // Ring buffer read port: 2-cycle latency, ready drops the cycle after each trigger, never reset.
  logic          pipe_vld = 1'b0;
  logic [DW-1:0] pipe_dat = '0;
  always @(posedge clk) begin
    pipe_vld <= rb_read_trigger_out;
    pipe_dat <= 32'hA000 + 32'(rb_read_addr_out);
    rb_vld   <= pipe_vld;
    rb_dat   <= pipe_dat;
    rb_ready <= !rb_read_trigger_out;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] out_dat[$];
  int          out_idx[$];
  logic        out_last[$];
  int          trig_addr[$];
  int          trig_cyc[$];
  int          n_trig, n_xfer, n_done, done_cyc, first_vld_cyc, last_trig_cyc;
  int          credit_viol, spacing_viol;
  logic        busy_at_done;

  task automatic clear_mon();
    out_dat.delete(); out_idx.delete(); out_last.delete();
    trig_addr.delete(); trig_cyc.delete();
    n_trig = 0; n_xfer = 0; n_done = 0; done_cyc = -1; first_vld_cyc = -1;
    last_trig_cyc = -10; credit_viol = 0; spacing_viol = 0; busy_at_done = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rb_read_trigger_out) begin
      // Triggers minus completed transfers equals outstanding reads plus FIFO occupancy.
      if ((n_trig - n_xfer) >= FD) credit_viol++;
      if (cyc - last_trig_cyc < 2) spacing_viol++;
      last_trig_cyc = cyc;
      trig_addr.push_back(int'(rb_read_addr_out));
      trig_cyc.push_back(cyc);
      n_trig++;
    end
    if (valid_out && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (valid_out && ready_in) begin
      out_dat.push_back(data_out);
      out_idx.push_back(int'(index_out));
      out_last.push_back(last_out);
      n_xfer++;
    end
    if (done_out) begin
      n_done++;
      done_cyc = cyc;
      busy_at_done = busy_out;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          base;
    int          len;
    int          stall_at;
    int          stall_len;
    int          poke_at;
    int          exp_ntrig;
    logic [31:0] exp_last_dat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int   k, stall_ctr, start_cyc, exp_off;
    logic busy_after;
    clear_mon();
    @(posedge clk); #1;
    base_in = AW'(v.base); len_in = LW'(v.len); start_in = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start_in = 1'b0;
    busy_after = busy_out;
    k = 0; stall_ctr = 0;
    while (n_done == 0 && k < 3000) begin
      if (v.poke_at == k) begin
        start_in = 1'b1; base_in = '0; len_in = LW'(3);
      end else begin
        start_in = 1'b0;
      end
      ready_in = !(v.stall_at >= 0 && n_xfer >= v.stall_at && stall_ctr < v.stall_len);
      if (!ready_in) stall_ctr++;
      @(posedge clk); #1;
      k++;
    end
    start_in = 1'b0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_start", busy_after, 1);
    chk("done_count", n_done, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("trigger_count", trig_addr.size(), v.exp_ntrig);
    chk("sample_count", out_dat.size(), v.len);
    chk("credit_violations", credit_viol, 0);
    chk("trigger_spacing", spacing_viol, 0);
    for (int i = 0; i < trig_addr.size() && i < v.len; i++)
      chk($sformatf("addr[%0d]", i), trig_addr[i], (v.base + i) % E);
    for (int i = 0; i < out_dat.size() && i < v.len; i++) begin
      exp_off = (v.base + i) % E;
      chk($sformatf("data[%0d]", i), out_dat[i], 32'hA000 + exp_off);
      chk($sformatf("index[%0d]", i), out_idx[i], i);
      chk($sformatf("last[%0d]", i), out_last[i], (i == v.len - 1) ? 1 : 0);
    end
    if (v.len > 0 && out_dat.size() > 0)
      chk("final_data", out_dat[out_dat.size()-1], v.exp_last_dat);
    if (v.len > 0 && v.stall_at < 0 && trig_cyc.size() > 0)
      chk("trigger_to_valid", first_vld_cyc - trig_cyc[0], 3);
    if (v.len == 0)
      chk("zero_len_done_latency", done_cyc - start_cyc, 2);
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    int w;
    vecs[0] = '{10,  8, -1,  0, -1,  8, 32'hA011};  // basic
    vecs[1] = '{30,  5, -1,  0, -1,  5, 32'hA002};  // wrap 30,31,0,1,2
    vecs[2] = '{ 3, 12,  2, 20, -1, 12, 32'hA00E};  // backpressure
    vecs[3] = '{ 5,  0, -1,  0, -1,  0, 32'h0};     // zero length
    vecs[4] = '{10,  8, -1,  0,  4,  8, 32'hA011};  // start while busy ignored
    vecs[5] = '{ 0, 32, -1,  0, -1, 32, 32'hA01F};  // full buffer
    vecs[6] = '{31,  1, -1,  0, -1,  1, 32'hA01F};  // single sample at top offset

    clear_mon();
    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trigger", rb_read_trigger_out, 0);
    chk("rst_addr", rb_read_addr_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_index", index_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    rst_in = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset one cycle after the first trigger; its late return must be dropped.
    clear_mon();
    @(posedge clk); #1;
    base_in = AW'(20); len_in = LW'(6); start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    w = 0;
    while (trig_addr.size() == 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rst_seq_trigger_seen", (trig_addr.size() > 0) ? 1 : 0, 1);
    @(posedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    chk("rst_seq_busy", busy_out, 0);
    chk("rst_seq_valid", valid_out, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_seq_no_outputs", out_dat.size(), 0);
    chk("rst_seq_no_done", n_done, 0);
    rv = '{0, 2, -1, 0, -1, 2, 32'hA001};
    run_vec(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ring_window_reader.md
Name: ring_window_reader

Overview:
- Read-side client for the sample ring buffer.
- On a start command it sweeps a window of LEN consecutive logical offsets, beginning at a base offset, through the buffer's read port. It then streams the returned samples to a downstream consumer with valid/ready backpressure.
- The buffer read port has a fixed 2-cycle latency and cannot stall. The block hides this with credit-limited issue and a small skid FIFO.
- Sits between the ring buffer and pitch-analysis datapaths (autocorrelation/difference stages).

Parameters:
- ENTRIES, 2048, depth of the attached ring buffer; logical offsets range 0..ENTRIES-1.
- DATA_WIDTH, 32, sample width.
- FIFO_DEPTH, 4, skid FIFO depth. Must be ≥ 3 (latency + 1) and a power of two.
- Derived: ADDRSIZE = $clog2(ENTRIES); LENSIZE = ADDRSIZE+1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- start_in  input  1  single-cycle sweep request; accepted only in IDLE
- base_in  input  ADDRSIZE  first logical offset; sampled with start_in
- len_in  input  LENSIZE  sample count, 0..ENTRIES; sampled with start_in
- rb_read_addr_out  output  ADDRSIZE  to ring buffer read_addr
- rb_read_trigger_out  output  1  to ring buffer read_trigger
- rb_read_ready_in  input  1  from ring buffer read_ready_out
- rb_data_in  input  DATA_WIDTH  from ring buffer data_out
- rb_data_valid_in  input  1  from ring buffer data_valid_out
- data_out  output  DATA_WIDTH  streamed sample
- index_out  output  ADDRSIZE  sample position within the window, 0..LEN-1
- last_out  output  1  high with the final sample (index LEN-1)
- valid_out  output  1  data_out/index_out/last_out valid
- ready_in  input  1  downstream accept; a transfer occurs when valid_out && ready_in
- busy_out  output  1  high from the cycle after start is accepted until done
- done_out  output  1  one-cycle pulse after the last transfer

Behaviour:
- Reset: all outputs 0; state IDLE; issue count, outstanding count, FIFO pointers and element counters cleared.
- States:
  - IDLE: start_in latches base/len. len==0 goes to DONE; otherwise goes to ISSUE.
  - ISSUE: issues reads. After the LEN-th issue, goes to DRAIN.
  - DRAIN: waits until outstanding==0, FIFO empty and all LEN transfers complete, then goes to DONE.
  - DONE: done_out=1 for one cycle, then IDLE.
  - start_in outside IDLE is ignored.
- Issue rule: in ISSUE, rb_read_trigger_out=1 when all of the following hold:
  - rb_read_ready_in=1
  - issued<len
  - outstanding + fifo_count < FIFO_DEPTH
- Consequence: at most one read every 2 cycles, because the buffer deasserts ready the cycle after each trigger.
- Issued address = base+issued when that sum < ENTRIES, else base+issued-ENTRIES. Compute at LENSIZE+1 width so no overflow occurs.
- rb_read_addr_out and rb_read_trigger_out are combinational from registered state. Address is held stable whenever trigger=0.
- Outstanding counter: +1 on trigger, -1 on rb_data_valid_in, both in the same cycle gives net 0.
- rb_data_valid_in arriving while outstanding==0 (stale after reset) is dropped.
- Each valid return is pushed into the FIFO with its index (a return counter).
  - Overflow is impossible by the credit rule; verification asserts it never happens.
- Output: valid_out = FIFO non-empty; data/index/last come from the FIFO head.
  - Pop on valid_out && ready_in.
  - Push and pop in the same cycle are both honoured.
  - With ready_in held high, the first sample appears 2 cycles after its trigger plus 1 cycle of FIFO registration (3-cycle trigger-to-valid_out).
- Samples emerge in index order 0..LEN-1; last_out is high only at index LEN-1.
- Window wrap: base=ENTRIES-2, len=4 issues addresses ENTRIES-2, ENTRIES-1, 0, 1.
- len==ENTRIES: every offset is read exactly once.
- Ring buffer shifts during a sweep are not the block's concern. Offsets are head-relative, so the caller must hold shift_trigger low while busy_out=1 to get a coherent window.
- rst_in mid-sweep: returns to IDLE next cycle, FIFO discarded, no done_out. Up to 2 in-flight returns arrive afterwards and are dropped by the outstanding==0 rule.

Test Plan:
- Basic sweep: base=10, len=8, ready_in=1, buffer preloaded with value=offset.
  - Addresses 10..17 issued, one per 2 cycles.
  - Outputs 10..17 with index 0..7; last_out only at index 7.
  - done_out pulses once; busy_out falls with it.
- Wrap: ENTRIES=16, base=14, len=5 → addresses 14, 15, 0, 1, 2; data in that order; no address ≥16.
- Backpressure: len=12, ready_in low for 20 cycles mid-sweep.
  - Issue stalls at FIFO_DEPTH credits.
  - No sample lost or duplicated; FIFO never overflows; order 0..11 preserved after release.
- Zero length and ignored start: len=0 → done_out 2 cycles after start, no rb_read_trigger_out. start_in pulsed while busy → ignored, current sweep unaffected.
- Full buffer: base=0, len=ENTRIES → every offset read exactly once; index_out reaches ENTRIES-1 with last_out.
- Reset mid-sweep: assert rst_in the cycle after a trigger, then start a new sweep base=0, len=2.
  - The stale return is dropped.
  - The new sweep outputs exactly 2 samples with correct values.
